// File: rtl/ipf_pkg.sv
// Shared constants for the IPF input-side feeder: command codes, FSM states, schedule sizes.
// No logic; compile before any module that imports it.
// Optional feature macro used by ipf_feeder: IPF_FEED_PERF_EN.
package ipf_pkg;

  // IPF command encoding; everything other than START/NEXT/DONE pulses is NOP
  localparam logic [2:0] CTRL_DONE  = 3'd0;
  localparam logic [2:0] CTRL_START = 3'd1;
  localparam logic [2:0] CTRL_NEXT  = 3'd2;
  localparam logic [2:0] CTRL_NOP   = 3'd7;

  // Default job schedule
  localparam int NUM_GROUPS_DEF = 4;
  localparam int I_BURST_DEF    = 8;
  localparam int W_BURST_L_DEF  = 5;
  localparam int W_BURST_S_DEF  = 4;
  localparam int COMP_CYC_DEF   = 32;

  // Width of the shared burst / compute counter (must hold COMP_CYC)
  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_I,
    ST_LOAD_W,
    ST_ISSUE,
    ST_COMP,
    ST_NEXT,
    ST_TERM,
    ST_WAIT_FIN
  } state_t;

  // Even groups load an input burst ahead of their weight burst
  function automatic logic grp_loads_input(input logic [2:0] grp);
    return ~grp[0];
  endfunction

endpackage

// File: rtl/ipf_rd_pipe.sv
// Read-return stage: aligns a qualifier with data coming back from a 1-cycle-latency SRAM port.
// The SRAM output register is the data stage; only the strobe is re-registered here.
// Data is forced to 0 whenever the qualifier is low so idle and reset outputs read as 0.
module ipf_rd_pipe #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] dat_o
);

  logic vld_q;

  // Delay the read strobe by the SRAM latency so it lines up with rdata
  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= rd_en_i;
  end

  assign vld_o = vld_q;
  assign dat_o = vld_q ? rdata_i : '0;

endmodule

// File: rtl/ipf_feeder.sv
// IPF input-side sequencer: fetches input/weight words and runs the 4-group load/compute schedule.
// Job length: first read 1 cycle after start, DONE 175 cycles after start, done 1 cycle after finish.
// Optional macro IPF_FEED_PERF_EN enables the saturating cycle_cnt job-length counter.
module ipf_feeder
  import ipf_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int I_AW       = 4,
  parameter int W_AW       = 4,
  parameter int W_DEPTH    = 9,
  parameter int NUM_GROUPS = NUM_GROUPS_DEF,
  parameter int I_BURST    = I_BURST_DEF,
  parameter int W_BURST_L  = W_BURST_L_DEF,
  parameter int W_BURST_S  = W_BURST_S_DEF,
  parameter int COMP_CYC   = COMP_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        wsize_cfg,
  output logic              i_rd_en,
  output logic [I_AW-1:0]   i_addr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              w_rd_en,
  output logic [W_AW-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_data,
  output logic              w_valid,
  output logic [DATA_W-1:0] w_data,
  output logic [2:0]        ctrl,
  output logic [1:0]        Wsize,
  input  logic              finish,
  output logic              busy,
  output logic              done,
  output logic [15:0]       cycle_cnt
);

  state_t           state_q;
  logic [2:0]       grp_q;
  logic [CNT_W-1:0] cnt_q;
  logic [I_AW-1:0]  i_ptr_q, i_addr_q;
  logic [W_AW-1:0]  w_ptr_q, w_addr_q;
  logic             i_rd_en_q, w_rd_en_q;
  logic [2:0]       ctrl_q;
  logic [1:0]       wsize_q;
  logic             busy_q, done_q;

  // Weight pointer after the current one, wrapping at the last stored word
  logic [W_AW-1:0]  w_ptr_nxt;
  assign w_ptr_nxt = (w_ptr_q == W_AW'(W_DEPTH - 1)) ? '0 : w_ptr_q + 1'b1;

  // Schedule FSM; every output is registered so state_q describes the visible cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grp_q     <= '0;
      cnt_q     <= '0;
      i_ptr_q   <= '0;
      i_addr_q  <= '0;
      w_ptr_q   <= '0;
      w_addr_q  <= '0;
      i_rd_en_q <= 1'b0;
      w_rd_en_q <= 1'b0;
      ctrl_q    <= CTRL_NOP;
      wsize_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      i_rd_en_q <= 1'b0;
      w_rd_en_q <= 1'b0;
      ctrl_q    <= CTRL_NOP;
      done_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            // Group 0 always loads input; pointers carry over from the last job
            wsize_q   <= wsize_cfg;
            grp_q     <= '0;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_LOAD_I;
            i_rd_en_q <= 1'b1;
            i_addr_q  <= i_ptr_q;
            i_ptr_q   <= i_ptr_q + 1'b1;
          end
        end
        ST_LOAD_I: begin
          if (cnt_q == CNT_W'(I_BURST - 1)) begin
            cnt_q     <= '0;
            state_q   <= ST_LOAD_W;
            w_rd_en_q <= 1'b1;
            w_addr_q  <= w_ptr_q;
            w_ptr_q   <= w_ptr_nxt;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            i_rd_en_q <= 1'b1;
            i_addr_q  <= i_ptr_q;
            i_ptr_q   <= i_ptr_q + 1'b1;
          end
        end
        ST_LOAD_W: begin
          if (cnt_q == (grp_loads_input(grp_q) ? CNT_W'(W_BURST_L - 1) : CNT_W'(W_BURST_S - 1))) begin
            state_q <= ST_ISSUE;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            w_rd_en_q <= 1'b1;
            w_addr_q  <= w_ptr_q;
            w_ptr_q   <= w_ptr_nxt;
          end
        end
        ST_ISSUE: begin
          // Last weight word is on w_data this cycle; START follows it directly
          ctrl_q  <= CTRL_START;
          cnt_q   <= '0;
          state_q <= ST_COMP;
        end
        ST_COMP: begin
          // First COMP cycle shows START, then COMP_CYC NOP cycles before NEXT
          if (cnt_q == CNT_W'(COMP_CYC)) begin
            ctrl_q  <= CTRL_NEXT;
            state_q <= ST_NEXT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_NEXT: begin
          cnt_q <= '0;
          if (grp_q == 3'(NUM_GROUPS - 1)) begin
            ctrl_q  <= CTRL_DONE;
            state_q <= ST_TERM;
          end else begin
            grp_q <= grp_q + 1'b1;
            if (grp_loads_input(grp_q + 1'b1)) begin
              state_q   <= ST_LOAD_I;
              i_rd_en_q <= 1'b1;
              i_addr_q  <= i_ptr_q;
              i_ptr_q   <= i_ptr_q + 1'b1;
            end else begin
              state_q   <= ST_LOAD_W;
              w_rd_en_q <= 1'b1;
              w_addr_q  <= w_ptr_q;
              w_ptr_q   <= w_ptr_nxt;
            end
          end
        end
        ST_TERM: begin
          state_q <= ST_WAIT_FIN;
        end
        ST_WAIT_FIN: begin
          if (finish) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ipf_rd_pipe #(.DATA_W(DATA_W)) u_i_pipe (
    .clk    (clk),
    .rst    (rst),
    .rd_en_i(i_rd_en_q),
    .rdata_i(i_rdata),
    .vld_o  (i_valid),
    .dat_o  (i_data)
  );

  ipf_rd_pipe #(.DATA_W(DATA_W)) u_w_pipe (
    .clk    (clk),
    .rst    (rst),
    .rd_en_i(w_rd_en_q),
    .rdata_i(w_rdata),
    .vld_o  (w_valid),
    .dat_o  (w_data)
  );

  assign i_rd_en = i_rd_en_q;
  assign i_addr  = i_addr_q;
  assign w_rd_en = w_rd_en_q;
  assign w_addr  = w_addr_q;
  assign ctrl    = ctrl_q;
  assign Wsize   = wsize_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef IPF_FEED_PERF_EN
  logic [15:0] cycle_cnt_q;

  // Count busy cycles of the current job, saturating; value holds after done
  always_ff @(posedge clk) begin
    if (rst)                               cycle_cnt_q <= '0;
    else if (state_q == ST_IDLE && start)  cycle_cnt_q <= '0;
    else if (busy_q && cycle_cnt_q != 16'hFFFF) cycle_cnt_q <= cycle_cnt_q + 1'b1;
  end

  assign cycle_cnt = cycle_cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_ipf_feeder.sv
// Bench for ipf_feeder: SRAM models, expected-event scoreboard, table of job scenarios.
module tb_ipf_feeder;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          finish = 1'b0;
  logic [1:0]    wsize_cfg = '0;
  logic          i_rd_en, w_rd_en, i_valid, w_valid, busy, done;
  logic [3:0]    i_addr, w_addr;
  logic [DW-1:0] i_rdata = '0, w_rdata = '0, i_data, w_data;
  logic [2:0]    ctrl;
  logic [1:0]    Wsize;
  logic [15:0]   cycle_cnt;

  ipf_feeder dut (
    .clk(clk), .rst(rst), .start(start), .wsize_cfg(wsize_cfg),
    .i_rd_en(i_rd_en), .i_addr(i_addr), .i_rdata(i_rdata),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
    .i_valid(i_valid), .i_data(i_data), .w_valid(w_valid), .w_data(w_data),
    .ctrl(ctrl), .Wsize(Wsize), .finish(finish), .busy(busy), .done(done),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffers with 1-cycle read latency
  logic [DW-1:0] mem_i [16];
  logic [DW-1:0] mem_w [16];
  always @(posedge clk) begin
    if (i_rd_en) i_rdata <= mem_i[i_addr];
    if (w_rd_en) w_rdata <= mem_w[w_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [63:0] val;
  } ev_t;

  ev_t q_ird[$], q_wrd[$], q_iv[$], q_wv[$], q_ctl[$];
  int  ip = 0;
  int  wp = 0;
  bit  mon_en = 1'b0;

  function automatic ev_t mk(input int c, input logic [63:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  // Expected schedule for a job whose start is sampled in cycle s
  task automatic push_schedule(input int s);
    int t;
    t = s + 1;
    for (int g = 0; g < 4; g++) begin
      if (g % 2 == 0) begin
        for (int k = 0; k < 8; k++) begin
          q_ird.push_back(mk(t, 64'(ip)));
          q_iv.push_back(mk(t + 1, mem_i[ip]));
          ip = (ip + 1) % 16;
          t++;
        end
      end
      for (int k = 0; k < ((g % 2 == 0) ? 5 : 4); k++) begin
        q_wrd.push_back(mk(t, 64'(wp)));
        q_wv.push_back(mk(t + 1, mem_w[wp]));
        wp = (wp == 8) ? 0 : wp + 1;
        t++;
      end
      q_ctl.push_back(mk(t + 1, 64'd1));
      q_ctl.push_back(mk(t + 34, 64'd2));
      t += 35;
    end
    q_ctl.push_back(mk(t, 64'd0));
  endtask

  // Monitor: every read strobe, valid and non-NOP command must match the next expected event
  always @(negedge clk) begin : mon
    ev_t e;
    if (mon_en) begin
      if (i_rd_en) begin
        if (q_ird.size() == 0) chk("unexpected i_rd_en", 64'd1, 64'd0);
        else begin e = q_ird.pop_front(); chk("i_rd cycle", 64'(cyc), 64'(e.cyc)); chk("i_addr", 64'(i_addr), e.val); end
      end
      if (w_rd_en) begin
        if (q_wrd.size() == 0) chk("unexpected w_rd_en", 64'd1, 64'd0);
        else begin e = q_wrd.pop_front(); chk("w_rd cycle", 64'(cyc), 64'(e.cyc)); chk("w_addr", 64'(w_addr), e.val); end
      end
      if (i_valid) begin
        if (q_iv.size() == 0) chk("unexpected i_valid", 64'd1, 64'd0);
        else begin e = q_iv.pop_front(); chk("i_valid cycle", 64'(cyc), 64'(e.cyc)); chk("i_data", i_data, e.val); end
      end
      if (w_valid) begin
        if (q_wv.size() == 0) chk("unexpected w_valid", 64'd1, 64'd0);
        else begin e = q_wv.pop_front(); chk("w_valid cycle", 64'(cyc), 64'(e.cyc)); chk("w_data", w_data, e.val); end
      end
      if (ctrl !== 3'd7) begin
        if (q_ctl.size() == 0) chk("unexpected ctrl", 64'(ctrl), 64'd7);
        else begin e = q_ctl.pop_front(); chk("ctrl cycle", 64'(cyc), 64'(e.cyc)); chk("ctrl code", 64'(ctrl), e.val); end
      end
    end
  end

  typedef struct {
    logic [1:0] wsize;
    int         fin_dly;   // cycles finish stays low after WAIT_FIN is entered
    bit         poke;      // stray start and finish pulses mid-job
    int         exp_cnt;   // cycle_cnt after done when the counter is built
  } vec_t;

  task automatic run_job(input vec_t v);
    int s, f, bad;
    bad = 0;
    @(negedge clk);
    s = cyc;
    f = s + 176 + v.fin_dly;
    start = 1'b1;
    wsize_cfg = v.wsize;
    push_schedule(s);
    @(negedge clk);
    start = 1'b0;
    wsize_cfg = ~v.wsize;
    chk("busy after start", 64'(busy), 64'd1);
    while (cyc < f) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      start  = v.poke && (cyc == s + 20);
      finish = (v.poke && (cyc == s + 30)) || (cyc == f);
    end
    chk("busy held until finish", 64'(bad), 64'd0);
    @(negedge clk);
    finish = 1'b0;
    chk("done pulse", 64'(done), 64'd1);
    chk("busy after done", 64'(busy), 64'd0);
    chk("Wsize latched", 64'(Wsize), 64'(v.wsize));
`ifdef IPF_FEED_PERF_EN
    chk("cycle_cnt", 64'(cycle_cnt), 64'(v.exp_cnt));
`else
    chk("cycle_cnt", 64'(cycle_cnt), 64'd0);
`endif
    @(negedge clk);
    chk("done single cycle", 64'(done), 64'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " i_rd_en"}, 64'(i_rd_en), 64'd0);
    chk({tag, " w_rd_en"}, 64'(w_rd_en), 64'd0);
    chk({tag, " i_valid"}, 64'(i_valid), 64'd0);
    chk({tag, " w_valid"}, 64'(w_valid), 64'd0);
    chk({tag, " ctrl"}, 64'(ctrl), 64'd7);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " Wsize"}, 64'(Wsize), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    int   s, r;
    tbl[0] = '{wsize: 2'd1, fin_dly: 0,   poke: 1'b0, exp_cnt: 176};
    tbl[1] = '{wsize: 2'd2, fin_dly: 100, poke: 1'b1, exp_cnt: 276};
    tbl[2] = '{wsize: 2'd3, fin_dly: 7,   poke: 1'b0, exp_cnt: 183};
    tbl[3] = '{wsize: 2'd0, fin_dly: 1,   poke: 1'b1, exp_cnt: 177};
    for (int k = 0; k < 16; k++) begin
      mem_i[k] = {$urandom, $urandom};
      mem_w[k] = {$urandom, $urandom};
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    chk("reset done", 64'(done), 64'd0);
    chk("reset i_addr", 64'(i_addr), 64'd0);
    chk("reset w_addr", 64'(w_addr), 64'd0);
    chk("reset i_data", i_data, 64'd0);
    chk("reset w_data", w_data, 64'd0);
    chk("reset cycle_cnt", 64'(cycle_cnt), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int n = 0; n < 4; n++) run_job(tbl[n]);

    // Reset during group 1 compute, with start raised alongside it
    @(negedge clk);
    s = cyc;
    start = 1'b1;
    wsize_cfg = 2'd2;
    push_schedule(s);
    @(negedge clk);
    start = 1'b0;
    r = s + 49 + 10;
    while (cyc < r) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    while (q_ird.size() > 0 && q_ird[$].cyc > r) void'(q_ird.pop_back());
    while (q_wrd.size() > 0 && q_wrd[$].cyc > r) void'(q_wrd.pop_back());
    while (q_iv.size()  > 0 && q_iv[$].cyc  > r) void'(q_iv.pop_back());
    while (q_wv.size()  > 0 && q_wv[$].cyc  > r) void'(q_wv.pop_back());
    while (q_ctl.size() > 0 && q_ctl[$].cyc > r) void'(q_ctl.pop_back());
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk_quiet("after mid-job reset");
    ip = 0;
    wp = 0;
    repeat (3) @(negedge clk);
    chk("idle after reset", 64'(busy), 64'd0);
    run_job(tbl[0]);

    repeat (5) @(negedge clk);
    chk("leftover i reads", 64'(q_ird.size()), 64'd0);
    chk("leftover w reads", 64'(q_wrd.size()), 64'd0);
    chk("leftover i_valid", 64'(q_iv.size()), 64'd0);
    chk("leftover w_valid", 64'(q_wv.size()), 64'd0);
    chk("leftover ctrl", 64'(q_ctl.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
